wb_trace_buffer: RTL and testbench
==================================

WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entry count; a power of two, minimum 2.
REQ-002 SHALL have parameter TS_WIDTH, default 16, meaning cycle-timestamp width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 SHALL have port wb_reg_write  input  1  meaning the writeback stage commits a register write this cycle.
REQ-006 SHALL have port wb_dest_reg  input  5  meaning the writeback destination register index.
REQ-007 SHALL have port wb_data  input  32  meaning the writeback data (mux output feeding the register file).
REQ-008 SHALL have port out_valid  output  1  meaning the head entry is available.
REQ-009 SHALL have port out_ready  input  1  meaning the consumer accepts the head entry this cycle.
REQ-010 SHALL have port out_entry  output  TS_WIDTH+37  meaning the head entry {timestamp, dest_reg, data}, MSB first.
REQ-011 SHALL have port count  output  log2(DEPTH)+1  meaning the number of entries held.
REQ-012 SHALL have port drop_count  output  8  meaning the number of writebacks lost to overflow, saturating.
REQ-013 SHALL have port overflow  output  1  meaning the sticky flag that at least one drop has occurred since reset.

Function
REQ-014 SHALL increment a TS_WIDTH-bit free-running cycle counter by 1 every cycle after reset, wrapping from all-ones to 0.
REQ-015 SHALL assert push when wb_reg_write=1 and wb_dest_reg!=0; SHALL ignore writes to register 0.
REQ-016 SHALL store {timestamp-counter value in the push cycle, wb_dest_reg, wb_data} at the tail on push.
REQ-017 SHALL assert pop when out_valid=1 and out_ready=1; SHALL remove the head at the clock edge.
REQ-018 SHALL behave as first-word-fall-through: out_valid=(count!=0), and out_entry presents the head combinationally from storage.
REQ-019 SHALL give a push-to-out_valid latency of 1 cycle when empty; SHALL hold out_entry stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, on push and pop in the same cycle with count in 1..DEPTH, perform both, leave count unchanged, and drop nothing.
REQ-021 SHALL, on push with count=DEPTH and no pop, discard the entry, leave storage unchanged, increment drop_count (saturate at 255), and set overflow.
REQ-022 SHALL, on push and pop with count=0, perform the push only; pop is impossible because out_valid=0.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; full/empty SHALL be derived from count, never from pointer equality alone.
REQ-024 SHALL exert no back-pressure on the pipeline: a push request is never stalled, only accepted or dropped.
REQ-025 SHALL keep overflow at 1 until reset once set; later pops SHALL NOT clear it.

Reset
REQ-026 SHALL, when reset=1 at an edge, set count=0, pointers=0, timestamp=0, drop_count=0, and overflow=0, so out_valid=0 on the next cycle.
REQ-027 SHALL let reset override any simultaneous push or pop; the entry in that cycle SHALL be lost without counting as a drop.
REQ-028 SHALL NOT require storage contents to be cleared by reset; out_entry is don't-care while out_valid=0.
REQ-029 SHALL start the first post-reset cycle with timestamp 0; a push in that cycle SHALL carry timestamp 0.

Verification
REQ-030 SHALL verify a single push: reset, then on cycle 3 wb_reg_write=1, dest=5, data=0xDEADBEEF -> next cycle out_valid=1, out_entry={16'd3,5'd5,32'hDEADBEEF}, count=1.
REQ-031 SHALL verify the register-0 filter: wb_reg_write=1, dest=0, data=0x1234 -> out_valid stays 0, count=0, drop_count=0.
REQ-032 SHALL verify overflow: with out_ready=0, push 10 entries (data 1..10) at DEPTH=8 -> count=8, drop_count=2, overflow=1; draining yields data 1..8 in order.
REQ-033 SHALL verify full simultaneous events: at count=8, push data 0x99 with out_ready=1 -> head popped, count stays 8, drop_count unchanged, 0x99 delivered last.
REQ-034 SHALL verify pointer wrap-around: stream 20 pushes with out_ready=1 every cycle -> every entry delivered once in order, count never exceeds 1, no drops.
REQ-035 SHALL verify reset mid-operation: reset asserted at count=5, drop_count=3, with a push in the same cycle -> next cycle count=0, out_valid=0, drop_count=0, overflow=0, timestamp=0.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// -----------------------------------------------------------------------------
// wb_trace_buffer
//
// Captures every committed writeback (register index + data) together with a
// free-running cycle timestamp into a small first-word-fall-through FIFO, so a
// trace consumer can drain it at its own pace. The pipeline is never stalled:
// a writeback arriving while the buffer is full is discarded and counted.
//
// Parameters
//   DEPTH     FIFO entry count (power of two, >= 2)
//   TS_WIDTH  width of the cycle timestamp
//
// Ports
//   clk           single clock, all state updates on the rising edge
//   reset         synchronous, active-high reset
//   wb_reg_write  writeback stage commits a register write this cycle
//   wb_dest_reg   writeback destination register index
//   wb_data       writeback data (value written to the register file)
//   out_valid     head entry is available (buffer not empty)
//   out_ready     consumer accepts the head entry this cycle
//   out_entry     head entry {timestamp, dest_reg, data}, MSB first
//   count         number of entries currently held
//   drop_count    writebacks lost to overflow, saturates at 255
//   overflow      sticky: at least one drop since reset
//
// Handshake: an entry transfers on a rising edge where out_valid=1 and
// out_ready=1. out_valid depends only on stored state, never on out_ready,
// and out_entry stays stable while out_valid=1 and out_ready=0.
// -----------------------------------------------------------------------------
module wb_trace_buffer #(
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wb_reg_write,
    input  logic [4:0]                wb_dest_reg,
    input  logic [31:0]               wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TS_WIDTH+36:0]      out_entry,
    output logic [$clog2(DEPTH):0]    count,
    output logic [7:0]                drop_count,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TS_WIDTH + 37;

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [EW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count_q;
    logic [TS_WIDTH-1:0] timestamp;
    logic [7:0]          drop_count_q;
    logic                overflow_q;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic push_req;
    logic is_empty;
    logic is_full;
    logic pop;
    logic push_accept;
    logic push_drop;

    always_comb begin
        // Writes to register 0 are architecturally invisible, so they are
        // not traced at all (neither stored nor counted as drops).
        push_req    = wb_reg_write && (wb_dest_reg != 5'd0);

        // Full/empty come from the occupancy counter; pointer equality alone
        // cannot tell full from empty.
        is_empty    = (count_q == '0);
        is_full     = (count_q == FULL_COUNT);

        pop         = !is_empty && out_ready;

        // When full, a simultaneous pop frees the slot the push needs, so
        // both happen and nothing is lost.
        push_accept = push_req && (!is_full || pop);
        push_drop   = push_req && is_full && !pop;
    end

    // ------------------------------------------------------------------
    // Free-running timestamp: 0 in the first cycle after reset, wraps
    // naturally from all-ones to 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            timestamp <= '0;
        end else begin
            timestamp <= timestamp + TS_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Storage: not cleared by reset; contents are only meaningful for
    // slots between rd_ptr and wr_ptr. Reset suppresses the write so a
    // push in the reset cycle leaves no trace.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && push_accept) begin
            mem[wr_ptr] <= {timestamp, wb_dest_reg, wb_data};
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy. DEPTH is a power of two, so plain AW-bit
    // increments wrap modulo DEPTH.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_accept, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Drop accounting: saturating counter plus a sticky flag that only
    // reset clears.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else if (push_drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: first-word-fall-through, head read combinationally.
    // ------------------------------------------------------------------
    assign out_valid  = !is_empty;
    assign out_entry  = mem[rd_ptr];
    assign count      = count_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
module tb_wb_trace_buffer;

  localparam int DEPTH    = 8;
  localparam int TS_WIDTH = 16;
  localparam int EW       = TS_WIDTH + 37;

  // ---------------- clock / reset ----------------
  logic                clk = 1'b0;
  logic                reset;
  logic                wb_reg_write;
  logic [4:0]          wb_dest_reg;
  logic [31:0]         wb_data;
  logic                out_valid;
  logic                out_ready;
  logic [EW-1:0]       out_entry;
  logic [3:0]          count;
  logic [7:0]          drop_count;
  logic                overflow;

  always #5 clk = ~clk;

  wb_trace_buffer #(.DEPTH(DEPTH), .TS_WIDTH(TS_WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_reg_write (wb_reg_write),
    .wb_dest_reg  (wb_dest_reg),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_entry    (out_entry),
    .count        (count),
    .drop_count   (drop_count),
    .overflow     (overflow)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]       exp_q[$];
  logic [TS_WIDTH-1:0] ts_model;
  int                  n_checks = 0;
  int                  n_fail   = 0;

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    ts_model = ts_model + 16'd1;
  endtask

  task automatic idle_inputs();
    wb_reg_write = 1'b0;
    wb_dest_reg  = 5'd0;
    wb_data      = 32'd0;
    out_ready    = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ts_model = '0;
    exp_q.delete();
  endtask

  task automatic drive_push(input logic [4:0] dest, input logic [31:0] data);
    wb_reg_write = 1'b1;
    wb_dest_reg  = dest;
    wb_data      = data;
  endtask

  task automatic stop_push();
    wb_reg_write = 1'b0;
    wb_dest_reg  = 5'd0;
    wb_data      = 32'd0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (count !== 4'd0) begin
      n_fail++; $display("FAIL reset_count: got %0d expected 0", count);
    end
    n_checks++;
    if (drop_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_drop_count: got %0d expected 0", drop_count);
    end
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow);
    end
  endtask

  task automatic test_single_push();
    do_reset();
    tick(); tick(); tick();            // now in cycle 3
    drive_push(5'd5, 32'hDEADBEEF);
    tick();
    stop_push();
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_out_valid: got %b expected 1", out_valid);
    end
    n_checks++;
    if (out_entry !== {16'd3, 5'd5, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL single_entry: got %h expected %h", out_entry, {16'd3, 5'd5, 32'hDEADBEEF});
    end
    n_checks++;
    if (count !== 4'd1) begin
      n_fail++; $display("FAIL single_count: got %0d expected 1", count);
    end
    // Head held while not accepted
    tick();
    n_checks++;
    if (out_entry !== {16'd3, 5'd5, 32'hDEADBEEF} || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_hold: got %h/%b expected %h/1", out_entry, out_valid, {16'd3, 5'd5, 32'hDEADBEEF});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || count !== 4'd0) begin
      n_fail++; $display("FAIL single_pop: got valid=%b count=%0d expected valid=0 count=0", out_valid, count);
    end
  endtask

  task automatic test_reg0_filter();
    do_reset();
    drive_push(5'd0, 32'h1234);
    tick();
    stop_push();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reg0_out_valid: got %b expected 0", out_valid);
    end
    n_checks++;
    if (count !== 4'd0) begin
      n_fail++; $display("FAIL reg0_count: got %0d expected 0", count);
    end
    n_checks++;
    if (drop_count !== 8'd0) begin
      n_fail++; $display("FAIL reg0_drop_count: got %0d expected 0", drop_count);
    end
  endtask

  task automatic test_overflow();
    logic [EW-1:0] exp;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive_push(5'(i), 32'(i));
      if (i <= DEPTH) exp_q.push_back({ts_model, 5'(i), 32'(i)});
      tick();
    end
    stop_push();
    n_checks++;
    if (count !== 4'd8) begin
      n_fail++; $display("FAIL ovf_count: got %0d expected 8", count);
    end
    n_checks++;
    if (drop_count !== 8'd2) begin
      n_fail++; $display("FAIL ovf_drop_count: got %0d expected 2", drop_count);
    end
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_entry !== exp) begin
        n_fail++; $display("FAIL ovf_drain[%0d]: got %h valid=%b expected %h", i, out_entry, out_valid, exp);
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ovf_empty: got count=%0d valid=%b expected 0/0", count, out_valid);
    end
    n_checks++;
    if (overflow !== 1'b1 || drop_count !== 8'd2) begin
      n_fail++; $display("FAIL ovf_sticky: got ovf=%b drops=%0d expected 1/2", overflow, drop_count);
    end
  endtask

  task automatic test_full_simultaneous();
    logic [EW-1:0] exp;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_push(5'(i + 1), 32'h10 + 32'(i));
      exp_q.push_back({ts_model, 5'(i + 1), 32'h10 + 32'(i)});
      tick();
    end
    n_checks++;
    if (count !== 4'd8) begin
      n_fail++; $display("FAIL full_pre_count: got %0d expected 8", count);
    end
    drive_push(5'd9, 32'h99);
    out_ready = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back({ts_model, 5'd9, 32'h99});
    tick();
    stop_push();
    out_ready = 1'b0;
    n_checks++;
    if (count !== 4'd8) begin
      n_fail++; $display("FAIL full_sim_count: got %0d expected 8", count);
    end
    n_checks++;
    if (drop_count !== 8'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL full_sim_drops: got drops=%0d ovf=%b expected 0/0", drop_count, overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      exp = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_entry !== exp) begin
        n_fail++; $display("FAIL full_sim_drain[%0d]: got %h valid=%b expected %h", i, out_entry, out_valid, exp);
      end
      tick();
    end
    out_ready = 1'b0;
    n_checks++;
    if (count !== 4'd0) begin
      n_fail++; $display("FAIL full_sim_empty: got %0d expected 0", count);
    end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] exp;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive_push(5'((i % 31) + 1), 32'h100 + 32'(i));
      exp_q.push_back({ts_model, 5'((i % 31) + 1), 32'h100 + 32'(i)});
      tick();
      exp = exp_q.pop_front();
      n_checks++;
      if (count > 4'd1 || out_valid !== 1'b1 || out_entry !== exp) begin
        n_fail++; $display("FAIL b2b[%0d]: got %h count=%0d valid=%b expected %h count<=1", i, out_entry, count, out_valid, exp);
      end
    end
    stop_push();
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (count !== 4'd0 || drop_count !== 8'd0) begin
      n_fail++; $display("FAIL b2b_end: got count=%0d drops=%0d expected 0/0", count, drop_count);
    end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    for (int i = 0; i < DEPTH + 260; i++) begin
      drive_push(5'd3, 32'(i));
      tick();
    end
    stop_push();
    n_checks++;
    if (drop_count !== 8'd255 || count !== 4'd8) begin
      n_fail++; $display("FAIL drop_saturate: got drops=%0d count=%0d expected 255/8", drop_count, count);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      drive_push(5'd4, 32'hA0 + 32'(i));
      tick();
    end
    stop_push();
    out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    n_checks++;
    if (count !== 4'd5 || drop_count !== 8'd3) begin
      n_fail++; $display("FAIL midrst_pre: got count=%0d drops=%0d expected 5/3", count, drop_count);
    end
    // Reset together with a push and a pop request
    reset = 1'b1;
    drive_push(5'd6, 32'h5555);
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    stop_push();
    out_ready = 1'b0;
    n_checks++;
    if (count !== 4'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_count: got count=%0d valid=%b expected 0/0", count, out_valid);
    end
    n_checks++;
    if (drop_count !== 8'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL midrst_drops: got drops=%0d ovf=%b expected 0/0", drop_count, overflow);
    end
    // Push in the first post-reset cycle must carry timestamp 0
    drive_push(5'd7, 32'hCAFE);
    tick();
    stop_push();
    n_checks++;
    if (out_valid !== 1'b1 || out_entry !== {16'd0, 5'd7, 32'hCAFE} || count !== 4'd1) begin
      n_fail++; $display("FAIL midrst_ts0: got %h valid=%b count=%0d expected %h/1/1", out_entry, out_valid, count, {16'd0, 5'd7, 32'hCAFE});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    ts_model = '0;
    reset    = 1'b1;
    idle_inputs();
    test_reset();
    test_single_push();
    test_reg0_filter();
    test_overflow();
    test_full_simultaneous();
    test_back_to_back();
    test_drop_saturate();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
